// File: rtl/rename_map_table_if.sv
// ============================================================================
// Module : rename_map_table_if (+ rename_map_table_pkg)
// Brief  : Rename lane, free-list and CDB bundle for the rename map table.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifndef N
`define N 2
`endif
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif

package rename_map_table_pkg;
    localparam int PRN_W = 6;
    typedef logic [PRN_W-1:0] PRN;
    typedef struct packed {
        logic valid;
        PRN   prn;
    } FREE_LIST_PACKET;
endpackage

interface rename_map_table_if #(
    parameter int N           = `N,
    parameter int ARCH_REG_SZ = `ARCH_REG_SZ
) ();
    import rename_map_table_pkg::*;
    localparam int AW = $clog2(ARCH_REG_SZ);

    logic            [N-1:0]         req_valid;
    logic            [N-1:0][AW-1:0] req_rs1;
    logic            [N-1:0][AW-1:0] req_rs2;
    logic            [N-1:0][AW-1:0] req_rd;
    logic            [N-1:0]         req_rd_wr;
    logic            [N-1:0]         pop_en;
    FREE_LIST_PACKET [N-1:0]         pop_packet;
    FREE_LIST_PACKET [N-1:0]         cdb_packet;
    PRN              [N-1:0]         rs1_prn;
    PRN              [N-1:0]         rs2_prn;
    logic            [N-1:0]         rs1_ready;
    logic            [N-1:0]         rs2_ready;
    PRN              [N-1:0]         rd_prn;
    PRN              [N-1:0]         old_prn;
    logic            [N-1:0]         rename_valid;

    modport master (
        output req_valid, req_rs1, req_rs2, req_rd, req_rd_wr, pop_packet, cdb_packet,
        input  pop_en, rs1_prn, rs2_prn, rs1_ready, rs2_ready, rd_prn, old_prn, rename_valid
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_rd, req_rd_wr, pop_packet, cdb_packet,
        output pop_en, rs1_prn, rs2_prn, rs1_ready, rs2_ready, rd_prn, old_prn, rename_valid
    );
endinterface

`default_nettype wire

// File: rtl/rename_map_table.sv
// ============================================================================
// Module : rename_map_table
// Brief  : N-wide register rename map with in-group forwarding and CDB bypass.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifndef N
`define N 2
`endif
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif

module rename_map_table
    import rename_map_table_pkg::*;
#(
    parameter int N           = `N,
    parameter int ARCH_REG_SZ = `ARCH_REG_SZ
) (
    input  wire logic                   clock,
    input  wire logic                   reset,
    rename_map_table_if.slave           bus,
    input  wire logic                   squash,
    input  wire PRN [ARCH_REG_SZ-1:0]   rrat_map
);

    localparam int AW = $clog2(ARCH_REG_SZ);

    PRN                     map_q [ARCH_REG_SZ];
    PRN                     map_d [ARCH_REG_SZ];
    logic [ARCH_REG_SZ-1:0] rdy_q;
    logic [ARCH_REG_SZ-1:0] rdy_d;

    logic [N-1:0] writer;
    logic [N-1:0] accept;
    logic [N-1:0] pop_en_c;
    logic         blocked;
    logic         active;

    // Acceptance stops at the first writer the free list could not serve.
    always_comb begin
        blocked  = 1'b0;
        active   = reset & ~squash;
        writer   = '0;
        accept   = '0;
        pop_en_c = '0;
        for (int i = 0; i < N; i++) begin
            writer[i] = bus.req_valid[i] & bus.req_rd_wr[i] & (bus.req_rd[i] != '0);
            if (writer[i] && !bus.pop_packet[i].valid) begin
                blocked = 1'b1;
            end
            accept[i]   = bus.req_valid[i] & active & ~blocked;
            pop_en_c[i] = writer[i] & active;
        end
    end

    function automatic logic cdb_hit(input PRN p);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (bus.cdb_packet[c].valid && (bus.cdb_packet[c].prn == p)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Returns {ready, prn}; the ascending scan leaves the highest older writer in place.
    function automatic logic [PRN_W:0] resolve(input logic [AW-1:0] rs, input int lane);
        logic [PRN_W:0] r;
        r = {rdy_q[rs] | cdb_hit(map_q[rs]), map_q[rs]};
        if (rs == '0) begin
            r = {1'b1, map_q[0]};
        end else begin
            for (int k = 0; k < N; k++) begin
                if ((k < lane) && accept[k] && writer[k] && (bus.req_rd[k] == rs)) begin
                    r = {1'b0, bus.pop_packet[k].prn};
                end
            end
        end
        return r;
    endfunction

    PRN   [N-1:0] rs1_prn_c;
    PRN   [N-1:0] rs2_prn_c;
    PRN   [N-1:0] rd_prn_c;
    PRN   [N-1:0] old_prn_c;
    logic [N-1:0] rs1_rdy_c;
    logic [N-1:0] rs2_rdy_c;

    always_comb begin
        logic [PRN_W:0] r1;
        logic [PRN_W:0] r2;
        logic [PRN_W:0] ro;
        r1        = '0;
        r2        = '0;
        ro        = '0;
        rs1_prn_c = '0;
        rs2_prn_c = '0;
        rd_prn_c  = '0;
        old_prn_c = '0;
        rs1_rdy_c = '0;
        rs2_rdy_c = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.req_valid[i]) begin
                r1           = resolve(bus.req_rs1[i], i);
                r2           = resolve(bus.req_rs2[i], i);
                ro           = resolve(bus.req_rd[i], i);
                rs1_prn_c[i] = r1[PRN_W-1:0];
                rs1_rdy_c[i] = r1[PRN_W];
                rs2_prn_c[i] = r2[PRN_W-1:0];
                rs2_rdy_c[i] = r2[PRN_W];
                old_prn_c[i] = ro[PRN_W-1:0];
                rd_prn_c[i]  = (accept[i] && writer[i]) ? bus.pop_packet[i].prn : '0;
            end
        end
    end

    assign bus.pop_en       = pop_en_c;
    assign bus.rename_valid = accept;
    assign bus.rs1_prn      = rs1_prn_c;
    assign bus.rs2_prn      = rs2_prn_c;
    assign bus.rs1_ready    = rs1_rdy_c;
    assign bus.rs2_ready    = rs2_rdy_c;
    assign bus.rd_prn       = rd_prn_c;
    assign bus.old_prn      = old_prn_c;

    // CDB wakeup is applied first so a same-edge remap of the entry overrides it.
    always_comb begin
        for (int a = 0; a < ARCH_REG_SZ; a++) begin
            map_d[a] = map_q[a];
        end
        rdy_d = rdy_q;
        if (squash) begin
            for (int a = 0; a < ARCH_REG_SZ; a++) begin
                map_d[a] = rrat_map[a];
            end
            rdy_d = '1;
        end else begin
            for (int a = 0; a < ARCH_REG_SZ; a++) begin
                if (cdb_hit(map_q[a])) begin
                    rdy_d[a] = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (accept[i] && writer[i]) begin
                    map_d[bus.req_rd[i]] = bus.pop_packet[i].prn;
                    rdy_d[bus.req_rd[i]] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int a = 0; a < ARCH_REG_SZ; a++) begin
                map_q[a] <= PRN'(a);
            end
            rdy_q <= '1;
        end else begin
            for (int a = 0; a < ARCH_REG_SZ; a++) begin
                map_q[a] <= map_d[a];
            end
            rdy_q <= rdy_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rename_map_table.sv
// ============================================================================
// Module : tb_rename_map_table
// Brief  : Directed scenarios plus randomized run against a table-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rename_map_table;
    import rename_map_table_pkg::*;

    localparam int N    = 2;
    localparam int ARCH = 32;
    localparam int AW   = 5;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               squash = 1'b0;
    PRN   [ARCH-1:0]    rrat_map = '0;

    rename_map_table_if #(.N(N), .ARCH_REG_SZ(ARCH)) bus ();

    rename_map_table #(.N(N), .ARCH_REG_SZ(ARCH)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .squash   (squash),
        .rrat_map (rrat_map)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Architectural view of the table: entry -> PRN, entry -> value available.
    PRN   m_map [ARCH];
    logic m_rdy [ARCH];
    logic [N-1:0] m_wr;
    logic [N-1:0] e_pop, e_rv, e_r1rdy, e_r2rdy;
    PRN   [N-1:0] e_r1, e_r2, e_rd, e_old;

    function automatic void model_reset();
        for (int a = 0; a < ARCH; a++) begin
            m_map[a] = PRN'(a);
            m_rdy[a] = 1'b1;
        end
    endfunction

    function automatic logic cdb_has(input PRN p);
        for (int c = 0; c < N; c++)
            if (bus.cdb_packet[c].valid && bus.cdb_packet[c].prn == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void src(input int lane, input logic [AW-1:0] rs, output PRN p, output logic r);
        p = m_map[rs];
        r = m_rdy[rs] || cdb_has(m_map[rs]);
        if (rs == 0) begin
            r = 1'b1;
            return;
        end
        for (int k = lane - 1; k >= 0; k--) begin
            if (e_rv[k] && m_wr[k] && bus.req_rd[k] == rs) begin
                p = bus.pop_packet[k].prn;
                r = 1'b0;
                return;
            end
        end
    endfunction

    function automatic void model_eval();
        int   cut;
        logic dummy;
        cut = N;
        for (int i = 0; i < N; i++)
            m_wr[i] = bus.req_valid[i] && bus.req_rd_wr[i] && (bus.req_rd[i] != 0);
        for (int i = N - 1; i >= 0; i--)
            if (m_wr[i] && !bus.pop_packet[i].valid) cut = i;
        e_pop = '0; e_rv = '0; e_r1rdy = '0; e_r2rdy = '0;
        e_r1 = '0; e_r2 = '0; e_rd = '0; e_old = '0;
        for (int i = 0; i < N; i++) begin
            e_pop[i] = m_wr[i] && !squash && reset;
            if (bus.req_valid[i]) begin
                e_rv[i] = (i < cut) && !squash && reset;
                e_rd[i] = (e_rv[i] && m_wr[i]) ? bus.pop_packet[i].prn : PRN'(0);
                src(i, bus.req_rs1[i], e_r1[i], e_r1rdy[i]);
                src(i, bus.req_rs2[i], e_r2[i], e_r2rdy[i]);
                src(i, bus.req_rd[i], e_old[i], dummy);
            end
        end
    endfunction

    function automatic void model_commit();
        logic hit [ARCH];
        model_eval();
        if (!reset) begin
            model_reset();
        end else if (squash) begin
            for (int a = 0; a < ARCH; a++) begin
                m_map[a] = rrat_map[a];
                m_rdy[a] = 1'b1;
            end
        end else begin
            for (int a = 0; a < ARCH; a++) hit[a] = cdb_has(m_map[a]);
            for (int a = 0; a < ARCH; a++) if (hit[a]) m_rdy[a] = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (e_rv[i] && m_wr[i]) begin
                    m_map[bus.req_rd[i]] = bus.pop_packet[i].prn;
                    m_rdy[bus.req_rd[i]] = 1'b0;
                end
            end
        end
    endfunction

    task automatic clear_inputs();
        bus.req_valid  = '0;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.req_rd     = '0;
        bus.req_rd_wr  = '0;
        bus.pop_packet = '0;
        bus.cdb_packet = '0;
        squash         = 1'b0;
    endtask

    task automatic set_lane(input int i, input int rs1, input int rs2, input int rd,
                            input logic wr, input logic gv, input int gprn);
        bus.req_valid[i]        = 1'b1;
        bus.req_rs1[i]          = AW'(rs1);
        bus.req_rs2[i]          = AW'(rs2);
        bus.req_rd[i]           = AW'(rd);
        bus.req_rd_wr[i]        = wr;
        bus.pop_packet[i].valid = gv;
        bus.pop_packet[i].prn   = PRN'(gprn);
    endtask

    task automatic advance();
        @(posedge clock);
        model_commit();
        @(negedge clock);
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        model_reset();
        @(negedge clock);
        set_lane(0, 5, 6, 7, 1'b1, 1'b1, 20);
        set_lane(1, 9, 0, 4, 1'b1, 1'b1, 21);
        #1;
        n_cmp++; if (bus.pop_en !== 2'b00) begin n_bad++; $display("FAIL reset_pop_en got %b want 00", bus.pop_en); end
        n_cmp++; if (bus.rename_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rename_valid got %b want 00", bus.rename_valid); end
        n_cmp++; if (bus.rs1_prn[1] !== PRN'(9) || bus.rs1_ready[1] !== 1'b1) begin n_bad++; $display("FAIL reset_identity got %0d/%b want 9/1", bus.rs1_prn[1], bus.rs1_ready[1]); end
        clear_inputs();
        reset = 1'b1;
    endtask

    task automatic test_basic();
        set_lane(0, 5, 6, 7, 1'b1, 1'b1, 40);
        #1;
        n_cmp++; if (bus.rs1_prn[0] !== PRN'(5) || bus.rs2_prn[0] !== PRN'(6)) begin n_bad++; $display("FAIL basic_src got %0d,%0d want 5,6", bus.rs1_prn[0], bus.rs2_prn[0]); end
        n_cmp++; if (bus.rs1_ready[0] !== 1'b1 || bus.rs2_ready[0] !== 1'b1) begin n_bad++; $display("FAIL basic_ready got %b%b want 11", bus.rs1_ready[0], bus.rs2_ready[0]); end
        n_cmp++; if (bus.old_prn[0] !== PRN'(7) || bus.rd_prn[0] !== PRN'(40)) begin n_bad++; $display("FAIL basic_rd got old %0d new %0d want 7 40", bus.old_prn[0], bus.rd_prn[0]); end
        n_cmp++; if (bus.rename_valid !== 2'b01 || bus.pop_en !== 2'b01) begin n_bad++; $display("FAIL basic_accept got rv %b pop %b want 01 01", bus.rename_valid, bus.pop_en); end
        advance();
        set_lane(0, 7, 0, 0, 1'b0, 1'b0, 0);
        #1;
        n_cmp++; if (bus.rs1_prn[0] !== PRN'(40) || bus.rs1_ready[0] !== 1'b0) begin n_bad++; $display("FAIL basic_map7 got %0d/%b want 40/0", bus.rs1_prn[0], bus.rs1_ready[0]); end
        advance();
    endtask

    task automatic test_intra_group();
        set_lane(0, 1, 2, 3, 1'b1, 1'b1, 41);
        set_lane(1, 3, 0, 3, 1'b1, 1'b1, 42);
        #1;
        n_cmp++; if (bus.rs1_prn[1] !== PRN'(41) || bus.rs1_ready[1] !== 1'b0) begin n_bad++; $display("FAIL intra_fwd got %0d/%b want 41/0", bus.rs1_prn[1], bus.rs1_ready[1]); end
        n_cmp++; if (bus.old_prn[1] !== PRN'(41) || bus.old_prn[0] !== PRN'(3)) begin n_bad++; $display("FAIL intra_old got %0d,%0d want 3,41", bus.old_prn[0], bus.old_prn[1]); end
        n_cmp++; if (bus.rd_prn[1] !== PRN'(42) || bus.rename_valid !== 2'b11) begin n_bad++; $display("FAIL intra_rd got %0d rv %b want 42 11", bus.rd_prn[1], bus.rename_valid); end
        advance();
        set_lane(0, 3, 0, 0, 1'b0, 1'b0, 0);
        #1;
        n_cmp++; if (bus.rs1_prn[0] !== PRN'(42)) begin n_bad++; $display("FAIL intra_final got %0d want 42", bus.rs1_prn[0]); end
        advance();
    endtask

    task automatic test_exhaustion();
        set_lane(0, 0, 0, 8, 1'b1, 1'b1, 43);
        set_lane(1, 0, 0, 9, 1'b1, 1'b0, 0);
        #1;
        n_cmp++; if (bus.rename_valid !== 2'b01 || bus.pop_en !== 2'b11) begin n_bad++; $display("FAIL exhaust_accept got rv %b pop %b want 01 11", bus.rename_valid, bus.pop_en); end
        n_cmp++; if (bus.rd_prn[1] !== PRN'(0) || bus.rd_prn[0] !== PRN'(43)) begin n_bad++; $display("FAIL exhaust_rd got %0d,%0d want 43,0", bus.rd_prn[0], bus.rd_prn[1]); end
        advance();
        set_lane(0, 8, 9, 0, 1'b0, 1'b0, 0);
        #1;
        n_cmp++; if (bus.rs1_prn[0] !== PRN'(43) || bus.rs2_prn[0] !== PRN'(9) || bus.rs2_ready[0] !== 1'b1) begin n_bad++; $display("FAIL exhaust_map got %0d,%0d/%b want 43,9/1", bus.rs1_prn[0], bus.rs2_prn[0], bus.rs2_ready[0]); end
        advance();
    endtask

    task automatic test_cdb();
        set_lane(0, 7, 0, 0, 1'b0, 1'b0, 0);
        bus.cdb_packet[0].valid = 1'b1;
        bus.cdb_packet[0].prn   = PRN'(40);
        #1;
        n_cmp++; if (bus.rs1_prn[0] !== PRN'(40) || bus.rs1_ready[0] !== 1'b1) begin n_bad++; $display("FAIL cdb_bypass got %0d/%b want 40/1", bus.rs1_prn[0], bus.rs1_ready[0]); end
        advance();
        set_lane(0, 7, 0, 0, 1'b0, 1'b0, 0);
        #1;
        n_cmp++; if (bus.rs1_ready[0] !== 1'b1) begin n_bad++; $display("FAIL cdb_latched got %b want 1", bus.rs1_ready[0]); end
        advance();
    endtask

    task automatic test_rd_zero();
        set_lane(0, 0, 0, 0, 1'b1, 1'b1, 50);
        #1;
        n_cmp++; if (bus.pop_en !== 2'b00 || bus.rd_prn[0] !== PRN'(0)) begin n_bad++; $display("FAIL rd0_pop got pop %b rd %0d want 00 0", bus.pop_en, bus.rd_prn[0]); end
        n_cmp++; if (bus.rename_valid !== 2'b01) begin n_bad++; $display("FAIL rd0_accept got %b want 01", bus.rename_valid); end
        advance();
        set_lane(0, 0, 0, 0, 1'b0, 1'b0, 0);
        #1;
        n_cmp++; if (bus.rs1_prn[0] !== PRN'(0) || bus.rs1_ready[0] !== 1'b1) begin n_bad++; $display("FAIL rd0_map got %0d/%b want 0/1", bus.rs1_prn[0], bus.rs1_ready[0]); end
        advance();
    endtask

    task automatic test_squash();
        for (int a = 0; a < ARCH; a++) rrat_map[a] = PRN'((a * 5 + 3) % 64);
        set_lane(0, 1, 2, 10, 1'b1, 1'b1, 51);
        set_lane(1, 10, 3, 11, 1'b1, 1'b1, 52);
        squash = 1'b1;
        #1;
        n_cmp++; if (bus.rename_valid !== 2'b00 || bus.pop_en !== 2'b00) begin n_bad++; $display("FAIL squash_block got rv %b pop %b want 00 00", bus.rename_valid, bus.pop_en); end
        advance();
        for (int a = 0; a < ARCH; a += 2) begin
            set_lane(0, a, 0, 0, 1'b0, 1'b0, 0);
            set_lane(1, a + 1, 0, 0, 1'b0, 1'b0, 0);
            #1;
            n_cmp++;
            if (bus.rs1_prn[0] !== PRN'((a * 5 + 3) % 64) || bus.rs1_prn[1] !== PRN'(((a + 1) * 5 + 3) % 64) || bus.rs1_ready !== 2'b11) begin
                n_bad++; $display("FAIL squash_restore a=%0d got %0d,%0d/%b want %0d,%0d/11", a, bus.rs1_prn[0], bus.rs1_prn[1], bus.rs1_ready, (a * 5 + 3) % 64, ((a + 1) * 5 + 3) % 64);
            end
            advance();
        end
    endtask

    task automatic test_random(input int cycles);
        logic ok, w;
        for (int c = 0; c < cycles; c++) begin
            ok = 1'b1;
            for (int i = 0; i < N; i++) begin
                bus.req_valid[i] = ($urandom % 4) != 0;
                bus.req_rd_wr[i] = ($urandom % 4) != 0;
                bus.req_rs1[i]   = AW'(($urandom % 2) ? $urandom_range(0, 3) : $urandom_range(0, 31));
                bus.req_rs2[i]   = AW'(($urandom % 2) ? $urandom_range(0, 3) : $urandom_range(0, 31));
                bus.req_rd[i]    = AW'(($urandom % 2) ? $urandom_range(0, 3) : $urandom_range(0, 31));
                w = bus.req_valid[i] && bus.req_rd_wr[i] && bus.req_rd[i] != 0;
                bus.pop_packet[i].prn   = PRN'($urandom_range(0, 63));
                bus.pop_packet[i].valid = w && ok && (($urandom % 5) != 0);
                if (w && !bus.pop_packet[i].valid) ok = 1'b0;
                bus.cdb_packet[i].valid = $urandom % 2;
                bus.cdb_packet[i].prn   = ($urandom % 2) ? m_map[$urandom_range(0, 31)] : PRN'($urandom_range(0, 63));
            end
            squash = ($urandom % 32) == 0;
            if (squash) for (int a = 0; a < ARCH; a++) rrat_map[a] = PRN'($urandom_range(0, 63));
            #1;
            model_eval();
            n_cmp++; if (bus.pop_en !== e_pop) begin n_bad++; $display("FAIL rand_pop_en c=%0d got %b want %b", c, bus.pop_en, e_pop); end
            n_cmp++; if (bus.rename_valid !== e_rv) begin n_bad++; $display("FAIL rand_rename_valid c=%0d got %b want %b", c, bus.rename_valid, e_rv); end
            n_cmp++; if (bus.rs1_prn !== e_r1 || bus.rs1_ready !== e_r1rdy) begin n_bad++; $display("FAIL rand_rs1 c=%0d got %h/%b want %h/%b", c, bus.rs1_prn, bus.rs1_ready, e_r1, e_r1rdy); end
            n_cmp++; if (bus.rs2_prn !== e_r2 || bus.rs2_ready !== e_r2rdy) begin n_bad++; $display("FAIL rand_rs2 c=%0d got %h/%b want %h/%b", c, bus.rs2_prn, bus.rs2_ready, e_r2, e_r2rdy); end
            n_cmp++; if (bus.rd_prn !== e_rd) begin n_bad++; $display("FAIL rand_rd_prn c=%0d got %h want %h", c, bus.rd_prn, e_rd); end
            n_cmp++; if (bus.old_prn !== e_old) begin n_bad++; $display("FAIL rand_old_prn c=%0d got %h want %h", c, bus.old_prn, e_old); end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        set_lane(0, 7, 3, 5, 1'b1, 1'b1, 60);
        set_lane(1, 5, 0, 6, 1'b1, 1'b1, 61);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.pop_en !== 2'b00 || bus.rename_valid !== 2'b00) begin n_bad++; $display("FAIL midreset_block got pop %b rv %b want 00 00", bus.pop_en, bus.rename_valid); end
        n_cmp++; if (bus.rs1_prn[0] !== PRN'(7) || bus.rs2_prn[0] !== PRN'(3) || bus.rs1_ready[0] !== 1'b1) begin n_bad++; $display("FAIL midreset_identity got %0d,%0d/%b want 7,3/1", bus.rs1_prn[0], bus.rs2_prn[0], bus.rs1_ready[0]); end
        advance();
        reset = 1'b1;
        set_lane(0, 5, 0, 5, 1'b1, 1'b1, 62);
        #1;
        n_cmp++; if (bus.rename_valid !== 2'b01 || bus.rs1_prn[0] !== PRN'(5) || bus.rd_prn[0] !== PRN'(62)) begin n_bad++; $display("FAIL midreset_first got rv %b src %0d rd %0d want 01 5 62", bus.rename_valid, bus.rs1_prn[0], bus.rd_prn[0]); end
        advance();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_intra_group();
        test_exhaustion();
        test_cdb();
        test_rd_zero();
        test_squash();
        test_random(1500);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule

`default_nettype wire

// File: doc/rename_map_table.md
RENAME_MAP_TABLE -- requirements
Module: rename_map_table

Interface
REQ-001 SHALL have parameter N, default `N, meaning the number of rename lanes and CDB lanes.
REQ-002 SHALL have parameter ARCH_REG_SZ, default `ARCH_REG_SZ, meaning the number of map entries; AW = $clog2(ARCH_REG_SZ).
REQ-003 SHALL have port clock, input, 1 bit: the sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, [N-1:0]: a rename request is present on lane i.
REQ-006 SHALL have ports req_rs1, req_rs2 and req_rd, input, [N-1:0][AW-1:0]: the architectural sources and destination per lane.
REQ-007 SHALL have port req_rd_wr, input, [N-1:0]: lane i writes its req_rd.
REQ-008 SHALL have port pop_en, output, [N-1:0]: the free-list pop request for each lane.
REQ-009 SHALL have port pop_packet, input, FREE_LIST_PACKET [N-1:0]: the free-list grant for each lane, returned in the same cycle.
REQ-010 SHALL have port cdb_packet, input, FREE_LIST_PACKET [N-1:0]: the completed PRN broadcasts.
REQ-011 SHALL have port squash, input, 1 bit: restore the table from rrat_map.
REQ-012 SHALL have port rrat_map, input, PRN [ARCH_REG_SZ-1:0]: the committed mapping.
REQ-013 SHALL have ports rs1_prn and rs2_prn, output, PRN [N-1:0]: the renamed sources.
REQ-014 SHALL have ports rs1_ready and rs2_ready, output, [N-1:0]: each source value is available.
REQ-015 SHALL have ports rd_prn and old_prn, output, PRN [N-1:0]: the new and previous mapping of rd.
REQ-016 SHALL have port rename_valid, output, [N-1:0]: lane i is accepted this cycle.

Function
REQ-017 SHALL hold state map[ARCH_REG_SZ] (PRN) and rdy[ARCH_REG_SZ] (1 bit) in flops; all rename outputs SHALL be combinational, with zero-cycle latency.
REQ-018 SHALL treat a lane as a writer when req_valid & req_rd_wr & (req_rd != 0); arch reg 0 SHALL never be remapped.
REQ-019 SHALL drive pop_en[i] = writer[i] & ~squash.
REQ-020 SHALL determine acceptance in order: let j be the lowest writer lane with pop_packet[j].valid = 0; then lanes 0..j-1 that are valid SHALL be accepted and lanes j..N-1 SHALL be rejected.
REQ-021 SHALL accept all valid lanes when no such j exists.
REQ-022 SHALL guarantee that a rejected lane with pop_en asserted also received no grant, since the free list grants a prefix; no PRN SHALL leak.
REQ-023 SHALL set rd_prn[i] = pop_packet[i].prn for accepted writers, and 0 otherwise.
REQ-024 SHALL compute source lookup for lane i as follows: the PRN comes from the highest accepted writer lane k<i with rd == rs, else from map[rs]; rs = 0 SHALL yield PRN map[0] with ready = 1.
REQ-025 SHALL compute source ready as follows: an intra-group forwarded source SHALL be 0; otherwise ready = rdy[rs] OR (a CDB lane is valid with prn == map[rs]), i.e. a same-cycle bypass.
REQ-026 SHALL compute old_prn[i] with the same forwarding as REQ-024, applied to rd.
REQ-027 SHALL, on the clock edge without squash, for each accepted writer in lane order, set map[rd] <= rd_prn and rdy[rd] <= 0, with the last lane winning on a duplicate rd.
REQ-028 SHALL, on the clock edge without squash, set rdy[a] <= 1 for every entry a whose current map[a] equals a valid CDB prn, unless the same edge remaps a.
REQ-029 SHALL, when squash = 1, force rename_valid = 0 and pop_en = 0, and on the edge load map <= rrat_map and rdy <= all 1; squash SHALL have priority over rename and CDB.
REQ-030 SHALL, when req_valid[i] = 0, drive all lane-i outputs to 0.
REQ-031 SHALL neither accept nor produce X: outputs SHALL be derived only from flops and inputs.

Reset
REQ-032 SHALL, while reset = 0 (asynchronously), set map[a] = a and rdy[a] = 1 for all a.
REQ-033 SHALL, while reset = 0, force pop_en = 0 and rename_valid = 0.
REQ-034 SHALL, when reset asserts mid-operation, discard any in-flight mapping; the free list is reset by the same reset.
REQ-035 SHALL accept the first rename request in the first cycle after reset deasserts.

Verification (N=2, ARCH_REG_SZ=32)
REQ-036 SHALL cover: after reset, lane0 rs1=5, rs2=6, rd=7 with grant prn 40 -> rs1_prn=5 and rs2_prn=6, both ready; old_prn=7; rd_prn=40; next cycle map[7]=40 and rdy[7]=0.
REQ-037 SHALL cover intra-group dependency: lane0 rd=3 (grant 41), lane1 rs1=3, rd=3 (grant 42) -> lane1 rs1_prn=41 with ready=0; lane1 old_prn=41; final map[3]=42.
REQ-038 SHALL cover free-list exhaustion: lane0 grant valid (prn 43), lane1 writer grant invalid -> rename_valid=2'b01 and map updates from lane0 only.
REQ-039 SHALL cover CDB: map[7]=40 and rdy=0, cdb prn 40 valid while lane0 reads rs1=7 -> rs1_ready=1 the same cycle, and rdy[7]=1 next cycle.
REQ-040 SHALL cover squash concurrent with valid requests: rename_valid=0 and pop_en=0; next cycle map equals rrat_map and all rdy=1.
REQ-041 SHALL cover rd=0 writer: pop_en=0, rd_prn=0, lane accepted, and map[0] unchanged.
